sc_backg_scroll_engine: RTL
===========================

Name: sc_backg_scroll_engine

Overview:
- Datapath stage directly downstream of the background state machine.
- Consumes that FSM's active-low clear, load (shift) and upcount strobes.
- Returns the active-low T0 (terminal count) flag, closing the CHECK→SHIFT/COUNT loop.
- Holds the scrolling road background (8 rows × 8 columns) for the LED-matrix display path; each load pushes a new pseudo-randomly drifting road row in at row 0.

Parameters:
- PRESC_WIDTH, 22, width of the upcount prescaler.
- TERMINAL_COUNT, 2500000, upcount pulses between scroll steps; must be ≥1 and fit PRESC_WIDTH.
- ROAD_WIDTH, 4, open road columns per row (1..7).
- ROAD_INIT, 2, edge position after reset/clear (0..8-ROAD_WIDTH).
- LFSR_SEED, 8'hB5, LFSR value after reset/clear; 8'h00 is replaced by 8'h01.

Ports:
- SC_STATEMACHINEBACKG_CLOCK_50  in  1  system clock, 50 MHz.
- SC_STATEMACHINEBACKG_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_BACKG_clear_InLow  in  1  synchronous clear, active low.
- SC_BACKG_load_InLow  in  1  shift/scroll strobe, active low.
- SC_BACKG_upcount_InLow  in  1  prescaler increment strobe, active low.
- SC_BACKG_T0_OutLow  out  1  terminal-count flag, active low.
- SC_BACKG_background_Out  out  64  {row7,…,row0}; bit = 1 means wall.
- SC_BACKG_edge_Out  out  3  current left road edge (column of first open cell).

Behaviour:
- Reset: SC_STATEMACHINEBACKG_RESET_InHigh, asynchronous, active-high; clock SC_STATEMACHINEBACKG_CLOCK_50. Asserting reset mid-operation applies immediately, no clock needed.
- Reset state: cnt=0, edge=ROAD_INIT, lfsr=LFSR_SEED, all rows = straight pattern.
- Reset output values: T0_OutLow=1; background=64'hC3C3C3C3C3C3C3C3 with defaults; edge_Out=2.
- Straight pattern: row bit i = 1 iff i<edge or i≥edge+ROAD_WIDTH.
- Priority per rising edge: clear_InLow=0 > load_InLow=0 > upcount_InLow=0 > hold.
- Clear: identical to reset state, but synchronous.
- Upcount:
  - if cnt<TERMINAL_COUNT then cnt←cnt+1.
  - at TERMINAL_COUNT, cnt saturates (no wrap).
- T0_OutLow: decoded from the register only (no input-to-output combinational path).
  - 0 iff cnt==TERMINAL_COUNT, else 1.
  - Valid the cycle after the increment that reaches terminal.
- Load (scroll step), all in one cycle:
  - cnt←0, so T0_OutLow=1 next cycle.
  - row[k]←row[k-1] for k=7..1; row7 content is discarded.
  - edge←edge_next.
  - row0←straight pattern computed with edge_next.
  - lfsr advances one step.
- Load is honoured regardless of cnt: a load with T0_OutLow=1 still scrolls and zeroes cnt.
- edge_next from current lfsr[1:0]:
  - 00 or 11: stay.
  - 01: left; edge-1, unless edge==0, then stay.
  - 10: right; edge+1, unless edge==8-ROAD_WIDTH, then stay.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Step: lfsr←{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances only on load; never reaches 0.
  - Current (pre-advance) value selects the move.
- Arithmetic: edge is 3-bit unsigned; bounds checks happen before add/subtract, so no wrap is possible.
- Simultaneous strobes: the FSM never asserts more than one, but the priority above is mandatory and verified.
- Loop timing: one upcount per COUNT-state visit; scroll period ≈ TERMINAL_COUNT FSM loops.

Test Plan:
1. Pulse reset mid-count (cnt=2) without clock → immediately cnt=0, T0_OutLow=1, background=64'hC3C3C3C3C3C3C3C3, edge_Out=2.
2. TERMINAL_COUNT=3; three single-cycle upcount pulses → T0_OutLow 1,1,0 after pulses 1,2,3; fourth pulse → T0_OutLow stays 0 (saturation).
3. After reset, with T0_OutLow=0, one load pulse:
   - lfsr=B5, bits[1:0]=01 → edge 2→1.
   - Next cycle: row0=8'hE1, rows1–7=8'hC3, lfsr=8'h6B, T0_OutLow=1.
4. Force edge=0 with lfsr[1:0]=01 → edge stays 0, row0=8'hF0. Force edge=4 with lfsr[1:0]=10 → edge stays 4, row0=8'h0F.
5. clear_InLow and load_InLow low in the same cycle after several scrolls → clear wins: background=64'hC3C3C3C3C3C3C3C3, edge=2, lfsr=8'hB5, cnt=0.
6. Closed loop with the background FSM, TERMINAL_COUNT=3, startButton high, 200 cycles:
   - one SHIFT (load) every 3 COUNT visits.
   - edge_Out always within 0..4.
   - T0_OutLow never low for more than the CHECK→SHIFT latency.

Source files
------------

// File: rtl/sc_backg_scroll_engine.sv
// Scrolling road background plus upcount prescaler driven by the background FSM strobes.
// Registered one-cycle update; no backpressure, every strobe is consumed on its clock edge.
module sc_backg_scroll_engine #(
    parameter int         PRESC_WIDTH    = 22,
    parameter int         TERMINAL_COUNT = 2500000,
    parameter int         ROAD_WIDTH     = 4,
    parameter int         ROAD_INIT      = 2,
    parameter logic [7:0] LFSR_SEED      = 8'hB5
) (
    input  logic        SC_STATEMACHINEBACKG_CLOCK_50,
    input  logic        SC_STATEMACHINEBACKG_RESET_InHigh,
    input  logic        SC_BACKG_clear_InLow,
    input  logic        SC_BACKG_load_InLow,
    input  logic        SC_BACKG_upcount_InLow,
    output logic        SC_BACKG_T0_OutLow,
    output logic [63:0] SC_BACKG_background_Out,
    output logic [2:0]  SC_BACKG_edge_Out
);

    localparam logic [PRESC_WIDTH-1:0] termCnt  = PRESC_WIDTH'(TERMINAL_COUNT);
    localparam logic [2:0]             edgeInit = 3'(ROAD_INIT);
    localparam logic [2:0]             edgeMax  = 3'(8 - ROAD_WIDTH);
    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [7:0]             lfsrInit = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [PRESC_WIDTH-1:0] cnt;
    logic [2:0]             edgePos;
    logic [2:0]             edgeNext;
    logic [7:0]             lfsr;
    logic [7:0]             lfsrNext;
    logic [7:0]             initRow;
    logic [7:0]             newRow;
    logic [63:0]            bgReg;

    function automatic logic [7:0] straightRow(input logic [2:0] e);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = (i < int'(e)) || (i >= int'(e) + ROAD_WIDTH);
        end
        return r;
    endfunction

    always_comb begin
        edgeNext = edgePos;
        case (lfsr[1:0])
            2'b01:   if (edgePos != 3'd0)    edgeNext = edgePos - 3'd1;
            2'b10:   if (edgePos != edgeMax) edgeNext = edgePos + 3'd1;
            default: edgeNext = edgePos;
        endcase
    end

    assign lfsrNext = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign initRow  = straightRow(edgeInit);
    assign newRow   = straightRow(edgeNext);

    always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
        if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
            cnt     <= '0;
            edgePos <= edgeInit;
            lfsr    <= lfsrInit;
            bgReg   <= {8{initRow}};
        end else if (!SC_BACKG_clear_InLow) begin
            cnt     <= '0;
            edgePos <= edgeInit;
            lfsr    <= lfsrInit;
            bgReg   <= {8{initRow}};
        end else if (!SC_BACKG_load_InLow) begin
            // Row 7 falls off the top; the fresh row enters at row 0.
            cnt     <= '0;
            edgePos <= edgeNext;
            lfsr    <= lfsrNext;
            bgReg   <= {bgReg[55:0], newRow};
        end else if (!SC_BACKG_upcount_InLow) begin
            if (cnt < termCnt) begin
                cnt <= cnt + PRESC_WIDTH'(1);
            end
        end
    end

    assign SC_BACKG_T0_OutLow      = (cnt != termCnt);
    assign SC_BACKG_background_Out = bgReg;
    assign SC_BACKG_edge_Out       = edgePos;

endmodule
